// File: rtl/mem_arbiter_if.sv
// Signal bundle between mem_arbiter, the two L1 caches and the memory/L2 port.
// The slave modport is the arbiter's view; master is the surrounding caches and memory.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 28,
    parameter int unsigned LINE_W = 128
);
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_ready;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_ready;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
        output i_rdata, i_ready, d_rdata, d_ready, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
        input  i_rdata, i_ready, d_rdata, d_ready, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one line-granular memory port between the I-cache and D-cache, one transaction at a time.
// Define MEM_ARB_DPRIO_EN for fixed D-cache priority on ties; default is round-robin.
module mem_arbiter (
    input  logic         clk,
    input  logic         proc_reset_n,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_I   = 2'd1,
        GNT_D   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t state;
    logic   i_req;
    logic   d_req;

    assign i_req = bus.i_read;
    assign d_req = bus.d_read | bus.d_write;

`ifdef MEM_ARB_DPRIO_EN
    // Grant sequencing: D wins every tie, no history kept
    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (d_req) begin
                        state <= GNT_D;
                    end else if (i_req) begin
                        state <= GNT_I;
                    end
                end
                GNT_I, GNT_D: begin
                    if (bus.mem_ready) begin
                        state <= RELEASE;
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
`else
    logic last_d;  // 1 when the D-cache completed the most recent transaction

    // Grant sequencing: on a tie the requester that did not complete last wins
    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            state  <= IDLE;
            last_d <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req && (!d_req || last_d)) begin
                        state <= GNT_I;
                    end else if (d_req) begin
                        state <= GNT_D;
                    end
                end
                GNT_I: begin
                    if (bus.mem_ready) begin
                        state  <= RELEASE;
                        last_d <= 1'b0;
                    end
                end
                GNT_D: begin
                    if (bus.mem_ready) begin
                        state  <= RELEASE;
                        last_d <= 1'b1;
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
`endif

    // Memory-side mux: the registered grant selects which cache drives the port
    always_comb begin
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (state)
            GNT_I: begin
                bus.mem_read = bus.i_read;
                bus.mem_addr = bus.i_addr;
            end
            GNT_D: begin
                // Write wins if a faulty D-cache raises both strobes
                bus.mem_write = bus.d_write;
                bus.mem_read  = bus.d_read & ~bus.d_write;
                bus.mem_addr  = bus.d_addr;
                bus.mem_wdata = bus.d_wdata;
            end
            default: begin
            end
        endcase
    end

    assign bus.i_ready = bus.mem_ready & (state == GNT_I);
    assign bus.d_ready = bus.mem_ready & (state == GNT_D);
    assign bus.i_rdata = bus.mem_rdata;
    assign bus.d_rdata = bus.mem_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic against a transaction-level ownership model.
module tb_mem_arbiter;
    localparam int unsigned ADDR_W      = 28;
    localparam int unsigned LINE_W      = 128;
    localparam int unsigned RAND_CYCLES = 2000;

    localparam bit H = 1'b1;
    localparam bit L = 1'b0;
    localparam logic [ADDR_W-1:0] NA = '0;
    localparam logic [LINE_W-1:0] NL = '0;
    localparam logic [ADDR_W-1:0] A1 = 28'h0000123;
    localparam logic [ADDR_W-1:0] A2 = 28'h0000040;
    localparam logic [ADDR_W-1:0] D1 = 28'h0FFFFFF;
    localparam logic [ADDR_W-1:0] D2 = 28'h0000080;
    localparam logic [ADDR_W-1:0] D3 = 28'h0ABCDE0;
    localparam logic [LINE_W-1:0] WD = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
    localparam logic [LINE_W-1:0] W2 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [LINE_W-1:0] RD = 128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A501;

    typedef struct packed {
        logic              i_read;
        logic              d_read;
        logic              d_write;
        logic [ADDR_W-1:0] i_addr;
        logic [ADDR_W-1:0] d_addr;
        logic [LINE_W-1:0] d_wdata;
        logic              mem_ready;
        logic [LINE_W-1:0] mem_rdata;
    } in_t;

    typedef struct packed {
        logic              mem_read;
        logic              mem_write;
        logic [ADDR_W-1:0] mem_addr;
        logic [LINE_W-1:0] mem_wdata;
        logic              i_ready;
        logic              d_ready;
        logic [LINE_W-1:0] i_rdata;
        logic [LINE_W-1:0] d_rdata;
    } out_t;

    typedef struct {
        in_t  stim;
        out_t want;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    vec_t vecs[$];

    // Reference model: who owns the port, whether we are in the post-completion gap,
    // and which requester completed most recently (1 = I, 2 = D).
    int owner       = 0;
    bit cooldown    = 1'b0;
    int last_served = 2;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

    mem_arbiter dut (
        .clk          (clk),
        .proc_reset_n (rst_n),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input int idx, input string field,
                       input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s[%0d] %s: actual=%h required=%h", tag, idx, field, act, req);
        end
    endtask

    task automatic check_out(input string tag, input int idx, input out_t e);
        cmp(tag, idx, "mem_read",  LINE_W'(bus.mem_read),  LINE_W'(e.mem_read));
        cmp(tag, idx, "mem_write", LINE_W'(bus.mem_write), LINE_W'(e.mem_write));
        cmp(tag, idx, "mem_addr",  LINE_W'(bus.mem_addr),  LINE_W'(e.mem_addr));
        cmp(tag, idx, "mem_wdata", bus.mem_wdata,          e.mem_wdata);
        cmp(tag, idx, "i_ready",   LINE_W'(bus.i_ready),   LINE_W'(e.i_ready));
        cmp(tag, idx, "d_ready",   LINE_W'(bus.d_ready),   LINE_W'(e.d_ready));
        cmp(tag, idx, "i_rdata",   bus.i_rdata,            e.i_rdata);
        cmp(tag, idx, "d_rdata",   bus.d_rdata,            e.d_rdata);
    endtask

    task automatic apply(input in_t c);
        bus.i_read    = c.i_read;
        bus.i_addr    = c.i_addr;
        bus.d_read    = c.d_read;
        bus.d_write   = c.d_write;
        bus.d_addr    = c.d_addr;
        bus.d_wdata   = c.d_wdata;
        bus.mem_ready = c.mem_ready;
        bus.mem_rdata = c.mem_rdata;
    endtask

    function automatic in_t mk_in(bit ir, bit dr, bit dw, logic [ADDR_W-1:0] ia,
                                  logic [ADDR_W-1:0] da, logic [LINE_W-1:0] wd,
                                  bit mr, logic [LINE_W-1:0] rd);
        in_t c;
        c.i_read    = ir;
        c.d_read    = dr;
        c.d_write   = dw;
        c.i_addr    = ia;
        c.d_addr    = da;
        c.d_wdata   = wd;
        c.mem_ready = mr;
        c.mem_rdata = rd;
        return c;
    endfunction

    function automatic out_t mk_out(bit mrd, bit mwr, logic [ADDR_W-1:0] a,
                                    logic [LINE_W-1:0] w, bit ir, bit dr);
        out_t o;
        o           = '0;
        o.mem_read  = mrd;
        o.mem_write = mwr;
        o.mem_addr  = a;
        o.mem_wdata = w;
        o.i_ready   = ir;
        o.d_ready   = dr;
        return o;
    endfunction

    // rdata is a pass-through, so the expectation is whatever the row drives on mem_rdata
    task automatic add(input in_t s, input out_t e);
        vec_t v;
        v.stim         = s;
        v.want         = e;
        v.want.i_rdata = s.mem_rdata;
        v.want.d_rdata = s.mem_rdata;
        vecs.push_back(v);
    endtask

    function automatic int tie_winner();
`ifdef MEM_ARB_DPRIO_EN
        return 2;
`else
        return (last_served == 2) ? 1 : 2;
`endif
    endfunction

    function automatic out_t model_out(input in_t c);
        out_t e;
        e = '0;
        if (owner == 1) begin
            e.mem_read = c.i_read;
            e.mem_addr = c.i_addr;
            e.i_ready  = c.mem_ready;
        end else if (owner == 2) begin
            e.mem_write = c.d_write;
            e.mem_read  = c.d_read && !c.d_write;
            e.mem_addr  = c.d_addr;
            e.mem_wdata = c.d_wdata;
            e.d_ready   = c.mem_ready;
        end
        e.i_rdata = c.mem_rdata;
        e.d_rdata = c.mem_rdata;
        return e;
    endfunction

    task automatic model_step(input in_t c);
        bit i_req;
        bit d_req;
        i_req = c.i_read;
        d_req = c.d_read || c.d_write;
        if (owner != 0) begin
            if (c.mem_ready) begin
                last_served = owner;
                owner       = 0;
                cooldown    = 1'b1;
            end
        end else if (cooldown) begin
            cooldown = 1'b0;
        end else if (i_req && d_req) begin
            owner = tie_winner();
        end else if (i_req) begin
            owner = 1;
        end else if (d_req) begin
            owner = 2;
        end
    endtask

    function automatic in_t rand_in();
        in_t c;
        int  k;
        c         = '0;
        c.i_read  = ($urandom_range(0, 2) != 0);
        k         = int'($urandom_range(0, 9));
        c.d_read  = (k >= 4 && k <= 6) || (k == 9);
        c.d_write = (k >= 7);
        c.i_addr  = ADDR_W'($urandom);
        c.d_addr  = ADDR_W'($urandom);
        c.d_wdata = {$urandom, $urandom, $urandom, $urandom};
        c.mem_ready = ($urandom_range(0, 2) == 0);
        c.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        return c;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        apply('0);
        repeat (2) @(negedge clk);
        check_out("reset", 0, '0);
        rst_n = 1'b1;
    endtask

    initial begin
        in_t  c;
        out_t e;

        // Round-robin from reset; the I-cache holds its request through RELEASE
`ifdef MEM_ARB_DPRIO_EN
        add(mk_in(H, H, L, A2, D2, W2, L, NL), mk_out(L, L, NA, NL, L, L));
        add(mk_in(H, H, L, A2, D2, W2, H, RD), mk_out(H, L, D2, W2, L, H));
        add(mk_in(H, H, L, A2, D2, W2, H, RD), mk_out(L, L, NA, NL, L, L));
        add(mk_in(H, L, L, A2, D2, W2, L, NL), mk_out(L, L, NA, NL, L, L));
        add(mk_in(H, L, L, A2, D2, W2, H, RD), mk_out(H, L, A2, NL, H, L));
        add(mk_in(H, H, L, A2, D2, W2, L, NL), mk_out(L, L, NA, NL, L, L));
        add(mk_in(H, H, L, A2, D2, W2, L, NL), mk_out(L, L, NA, NL, L, L));
        add(mk_in(H, H, L, A2, D2, W2, H, RD), mk_out(H, L, D2, W2, L, H));
        add(mk_in(L, H, L, A2, D2, W2, L, NL), mk_out(L, L, NA, NL, L, L));
`else
        add(mk_in(H, H, L, A2, D2, W2, L, NL), mk_out(L, L, NA, NL, L, L));
        add(mk_in(H, H, L, A2, D2, W2, H, RD), mk_out(H, L, A2, NL, H, L));
        add(mk_in(H, H, L, A2, D2, W2, H, RD), mk_out(L, L, NA, NL, L, L));
        add(mk_in(L, H, L, A2, D2, W2, L, NL), mk_out(L, L, NA, NL, L, L));
        add(mk_in(L, H, L, A2, D2, W2, H, RD), mk_out(H, L, D2, W2, L, H));
        add(mk_in(H, H, L, A2, D2, W2, L, NL), mk_out(L, L, NA, NL, L, L));
        add(mk_in(H, H, L, A2, D2, W2, L, NL), mk_out(L, L, NA, NL, L, L));
        add(mk_in(H, H, L, A2, D2, W2, H, RD), mk_out(H, L, A2, NL, H, L));
        add(mk_in(L, H, L, A2, D2, W2, L, NL), mk_out(L, L, NA, NL, L, L));
`endif
        // Single I read, memory answers on the fourth granted cycle
        add(mk_in(H, L, L, A1, NA, NL, L, NL), mk_out(L, L, NA, NL, L, L));
        add(mk_in(H, L, L, A1, NA, NL, L, NL), mk_out(H, L, A1, NL, L, L));
        add(mk_in(H, L, L, A1, NA, NL, L, NL), mk_out(H, L, A1, NL, L, L));
        add(mk_in(H, L, L, A1, NA, NL, L, NL), mk_out(H, L, A1, NL, L, L));
        add(mk_in(H, L, L, A1, NA, NL, H, RD), mk_out(H, L, A1, NL, H, L));
        add(mk_in(L, L, L, A1, NA, NL, L, NL), mk_out(L, L, NA, NL, L, L));
        add(mk_in(L, L, L, A1, NA, NL, L, NL), mk_out(L, L, NA, NL, L, L));
        // Single D write with the request dropped for one cycle mid-grant
        add(mk_in(L, L, H, NA, D1, WD, L, NL), mk_out(L, L, NA, NL, L, L));
        add(mk_in(L, L, H, NA, D1, WD, L, NL), mk_out(L, H, D1, WD, L, L));
        add(mk_in(L, L, L, NA, D1, WD, L, NL), mk_out(L, L, D1, WD, L, L));
        add(mk_in(L, L, H, NA, D1, WD, H, RD), mk_out(L, H, D1, WD, L, H));
        add(mk_in(L, L, L, NA, D1, WD, L, NL), mk_out(L, L, NA, NL, L, L));
        add(mk_in(L, L, L, NA, D1, WD, L, NL), mk_out(L, L, NA, NL, L, L));
        // Illegal read+write, then a stray ready in IDLE before an I read
        add(mk_in(L, H, H, NA, D3, W2, L, NL), mk_out(L, L, NA, NL, L, L));
        add(mk_in(L, H, H, NA, D3, W2, H, RD), mk_out(L, H, D3, W2, L, H));
        add(mk_in(L, L, L, NA, NA, NL, L, NL), mk_out(L, L, NA, NL, L, L));
        add(mk_in(L, L, L, NA, NA, NL, H, RD), mk_out(L, L, NA, NL, L, L));
        add(mk_in(H, L, L, A1, NA, NL, L, NL), mk_out(L, L, NA, NL, L, L));
        add(mk_in(H, L, L, A1, NA, NL, H, RD), mk_out(H, L, A1, NL, H, L));
        add(mk_in(L, L, L, NA, NA, NL, L, NL), mk_out(L, L, NA, NL, L, L));
        add(mk_in(L, L, L, NA, NA, NL, L, NL), mk_out(L, L, NA, NL, L, L));

        rst_n = 1'b0;
        apply('0);
        do_reset();

        // Stray ready in IDLE must not move the arbiter
        c = '0;
        c.mem_ready = 1'b1;
        @(posedge clk); #1; apply(c);
        @(negedge clk); check_out("stray_idle", 0, '0);
        c.mem_ready = 1'b0;
        c.d_read    = 1'b1;
        c.d_addr    = 28'h0000ABC;
        @(posedge clk); #1; apply(c);
        @(negedge clk); check_out("stray_still_idle", 0, '0);
        c.mem_ready = 1'b1;
        @(posedge clk); #1; apply(c);
        e = mk_out(H, L, 28'h0000ABC, NL, L, H);
        @(negedge clk); check_out("stray_then_grant", 0, e);
        @(posedge clk); #1; apply('0);

        // Asynchronous reset in the middle of an I-cache grant
        do_reset();
        c = '0;
        c.i_read = 1'b1;
        c.i_addr = 28'h0000010;
        @(posedge clk); #1; apply(c);
        @(negedge clk); check_out("rmg_idle", 0, '0);
        c.mem_ready = 1'b1;
        @(posedge clk); #1; apply(c);
        e = mk_out(H, L, 28'h0000010, NL, H, L);
        @(negedge clk); check_out("rmg_granted", 0, e);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("rmg_async_drop", 0, '0);
        c.mem_ready = 1'b0;
        apply(c);
        @(negedge clk); check_out("rmg_held_reset", 0, '0);
        rst_n = 1'b1;
        e = mk_out(H, L, 28'h0000010, NL, L, L);
        @(negedge clk); check_out("rmg_regrant", 0, e);
        c.mem_ready = 1'b1;
        @(posedge clk); #1; apply(c);
        e.i_ready = 1'b1;
        @(negedge clk); check_out("rmg_complete", 0, e);
        @(posedge clk); #1; apply('0);

        // Directed vector table
        do_reset();
        foreach (vecs[k]) begin
            @(posedge clk); #1; apply(vecs[k].stim);
            @(negedge clk); check_out("vec", k, vecs[k].want);
        end

        // Randomized traffic against the ownership model
        do_reset();
        owner       = 0;
        cooldown    = 1'b0;
        last_served = 2;
        for (int n = 0; n < int'(RAND_CYCLES); n++) begin
            @(posedge clk); #1;
            c = rand_in();
            apply(c);
            @(negedge clk);
            check_out("rand", n, model_out(c));
            model_step(c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares one 128-bit line-granular memory port between the instruction cache (read-only) and the data cache (read/write) in the L2 cache extension. It sits between both L1 caches and the memory/L2 interface. It grants the port to one requester at a time and holds the grant for a full transaction until `mem_ready`. It then inserts a one-cycle release gap so the winning cache can drop its request.

## Interface
- `ADDR_W`, 28: line address width (word address bits [29:2]).
- `LINE_W`, 128: line data width.
- `clk` input 1: single clock, rising edge.
- `proc_reset_n` input 1: asynchronous, active-low reset.
- `i_read` input 1: I-cache line read request, held until its `i_ready`.
- `i_addr` input ADDR_W: I-cache line address.
- `i_rdata` output LINE_W: read data to the I-cache.
- `i_ready` output 1: one-cycle completion pulse to the I-cache.
- `d_read` input 1: D-cache line read request.
- `d_write` input 1: D-cache line write-back request (never asserted together with `d_read`).
- `d_addr` input ADDR_W: D-cache line address.
- `d_wdata` input LINE_W: D-cache write data.
- `d_rdata` output LINE_W: read data to the D-cache.
- `d_ready` output 1: one-cycle completion pulse to the D-cache.
- `mem_read` output 1: downstream read strobe.
- `mem_write` output 1: downstream write strobe.
- `mem_addr` output ADDR_W: downstream address.
- `mem_wdata` output LINE_W: downstream write data.
- `mem_rdata` input LINE_W: downstream read data, valid while `mem_ready` is high.
- `mem_ready` input 1: downstream completion, high for exactly one cycle.

## Operation

**States**
- `IDLE`: no transaction is granted.
- `GNT_I`: the I-cache owns the port.
- `GNT_D`: the D-cache owns the port.
- `RELEASE`: one-cycle gap after a transaction completes.

**State transitions**
- `IDLE`:
  - I request only (`i_read`) goes to `GNT_I`.
  - D request only (`d_read|d_write`) goes to `GNT_D`.
  - Both requesting: the tie-break rule below decides.
  - Neither requesting: stay in `IDLE`.
- `GNT_x` moves to `RELEASE` in the cycle `mem_ready`=1. Otherwise it stays in `GNT_x`.
- `RELEASE` always moves to `IDLE` after one cycle. Both requests are ignored during this cycle.

**Outputs**
- In `GNT_I`: `mem_read`=`i_read`, `mem_write`=0, `mem_addr`=`i_addr`, `mem_wdata`=0.
- In `GNT_D`: `mem_read`=`d_read`, `mem_write`=`d_write`, `mem_addr`=`d_addr`, `mem_wdata`=`d_wdata`.
- In `IDLE` and `RELEASE`: all `mem_*` outputs are 0.
- `i_rdata` and `d_rdata` both carry `mem_rdata` unconditionally, as a pure pass-through.
- `i_ready`=`mem_ready & (state==GNT_I)`.
- `d_ready`=`mem_ready & (state==GNT_D)`.
- The non-granted requester never sees a ready pulse.

**Grant hold**
- The grant persists until `mem_ready`, even if the granted requester drops its request early.
- While the request is dropped, the `mem_*` strobes follow the input, i.e. they drop to 0.

**Tie-break**
- Round-robin. A `last` flop records the most recently completed grant.
- When both requesters are asking, the one that is not `last` wins.
- `last` updates on the `GNT_x` to `RELEASE` transition.
- `last` resets to D, so I wins the first tie.

**Boundary conditions**
- `mem_ready` arriving while in `IDLE` or `RELEASE`: ignored. No ready pulse is produced and no state change occurs.
- `d_read` and `d_write` both high: illegal input. `mem_write` takes precedence and `mem_read` is forced to 0.
- Reset asserted mid-transaction: the state returns to `IDLE` asynchronously and all outputs go to 0 at once. The in-flight transaction is abandoned.

## Timing
- Reset values: `state`=`IDLE`, `last`=D.
- All outputs are 0 under reset, including both rdata buses, because `mem_rdata` is required to be 0 then.
- Request to `mem_*` assertion: 1 cycle. The grant is registered at the clock edge that leaves `IDLE`.
- `mem_ready` to requester ready: 0 cycles (combinational).
- Minimum gap between back-to-back transactions: 2 cycles, made up of `RELEASE` plus `IDLE`.
- Minimum transaction occupancy: request at cycle t, grant at t+1, earliest `mem_ready` at t+1, `RELEASE` at t+2, `IDLE` at t+3.
- The only flops are `state` (2 bits) and `last` (1 bit).
- No combinational path from requester inputs to `state`; requester inputs reach `mem_*` only through the registered grant mux.

## Configuration
- `MEM_ARB_DPRIO_EN` defined:
  - Fixed priority; D wins every tie in `IDLE`.
  - The `last` flop is not implemented.
  - Starvation of I under continuous D traffic is accepted.
- Not defined: round-robin as specified above.

## Test plan
- **Reset mid-grant:** `i_read`=1, `i_addr`=28'h0000010. Assert `proc_reset_n`=0 in the cycle `mem_read` is high, asynchronously between edges → `mem_read`, `mem_addr` and `i_ready` drop to 0 without waiting for a clock edge. After release, I is re-granted 1 cycle later.
- **Single I read:** `i_read`=1, `i_addr`=28'h0000123; memory returns `mem_rdata`=128'hA5A5…01 with `mem_ready` on cycle 4 → `mem_read`=1 and `mem_addr`=28'h0000123 from cycle 1. `i_ready`=1 and `i_rdata`=128'hA5A5…01 on cycle 4 only. `d_ready` stays 0. `mem_read`=0 on cycles 5 and 6.
- **Single D write:** `d_write`=1, `d_addr`=28'h0FFFFFF, `d_wdata`=128'hDEAD…BEEF → `mem_write`=1 with that address and data, `mem_read`=0. `d_ready` pulses with `mem_ready`.
- **Simultaneous requests, round-robin:** both request from reset → I is served first, then D. After that, both request again → I wins again (`last`=D). With `MEM_ARB_DPRIO_EN` → D is served first in both rounds.
- **Held request across RELEASE:** the I-cache keeps `i_read`=1 for one cycle after `i_ready` while D is requesting → no `mem_read` in `RELEASE`, D is granted next. I does not get a duplicate transaction.
- **Stray ready:** pulse `mem_ready` in `IDLE` with no requests → no `i_ready` or `d_ready`, state stays `IDLE`.
